mixer_n: RTL and testbench

- Parametrised N-channel successor to the two-channel sample mixer.
- Holds one sample latch per channel, written by channel index. Each channel has a shift-based attenuation level, with one level code reserved for mute.
- On command, snapshots all channels and sums them one channel per clock into an output register, then pulses o_valid.
- Sits between the oscillator/sample sources and the DAC output stage. Single clock domain.

---
 rtl/mixer_n.sv | 136 +++++++++++++
 tb/tb_mixer_n.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_n.sv
// N-channel sample mixer: per-channel latches, shift attenuation with a mute code,
// sequential one-channel-per-clock summation. Optional clamp via MIXER_N_SATURATE_EN.
module mixer_n #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 8,
    parameter int LEVEL_W  = 3,
    parameter int OUT_W    = 10
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic [SAMPLE_W-1:0]         i_sample,
    input  logic                        i_load,
    input  logic [$clog2(NUM_CH)-1:0]   i_load_ch,
    input  logic [NUM_CH*LEVEL_W-1:0]   i_levels,
    input  logic                        i_execute,
    output logic                        o_busy,
    output logic                        o_valid,
    output logic [OUT_W-1:0]            o_output
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ACC_W = SAMPLE_W + CH_W;
    localparam int SLOTS = 1 << CH_W;
    localparam logic [LEVEL_W-1:0] MUTE = '1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                capture;

    // Storage is padded to a power of two so the channel counter can index it directly.
    logic [SAMPLE_W-1:0] latch_q [SLOTS];
    logic [SAMPLE_W-1:0] snap_q  [SLOTS];
    logic [LEVEL_W-1:0]  lvl_q   [SLOTS];
    logic [SLOTS*LEVEL_W-1:0] levels_pad;

    logic [LEVEL_W-1:0]  cur_lvl;
    logic [SAMPLE_W-1:0] cur_term;
    logic [ACC_W-1:0]    sum;
    logic [OUT_W-1:0]    fin;

    assign levels_pad = (SLOTS*LEVEL_W)'(i_levels);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < SLOTS; k++) latch_q[k] <= '0;
        end else if (i_load && (int'(i_load_ch) < NUM_CH)) begin
            latch_q[i_load_ch] <= i_sample;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < SLOTS; k++) begin
                snap_q[k] <= '0;
                lvl_q[k]  <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < SLOTS; k++) begin
                snap_q[k] <= latch_q[k];
                lvl_q[k]  <= levels_pad[k*LEVEL_W +: LEVEL_W];
            end
        end
    end

    assign cur_lvl  = lvl_q[ch_q];
    assign cur_term = (cur_lvl == MUTE) ? '0 : (snap_q[ch_q] >> cur_lvl);
    assign sum      = acc_q + ACC_W'(cur_term);

`ifdef MIXER_N_SATURATE_EN
    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'({OUT_W{1'b1}});
    assign fin = (sum > OUT_MAX) ? '1 : sum[OUT_W-1:0];
`else
    assign fin = sum[OUT_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ch_d    = ch_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        out_d   = out_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_execute) begin
                    capture = 1'b1;
                    acc_d   = '0;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = sum;
                ch_d  = ch_q + 1'b1;
                if (int'(ch_q) == NUM_CH - 1) begin
                    out_d   = fin;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_valid  = valid_q;
    assign o_output = out_q;

endmodule

// File: tb/tb_mixer_n.sv
// Directed bench for mixer_n: default instance, a 9-bit-output instance and a 3-channel instance.
module tb_mixer_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic [7:0]  a_sample = '0, b_sample = '0, c_sample = '0;
    logic        a_load = 0, b_load = 0, c_load = 0;
    logic [1:0]  a_ch = '0, b_ch = '0, c_ch = '0;
    logic [11:0] a_levels = '0, b_levels = '0;
    logic [8:0]  c_levels = '0;
    logic        a_exec = 0, b_exec = 0, c_exec = 0;
    logic        a_busy, b_busy, c_busy, a_valid, b_valid, c_valid;
    logic [9:0]  a_out, c_out;
    logic [8:0]  b_out;

    mixer_n dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_sample(a_sample), .i_load(a_load),
        .i_load_ch(a_ch), .i_levels(a_levels), .i_execute(a_exec),
        .o_busy(a_busy), .o_valid(a_valid), .o_output(a_out));

    mixer_n #(.OUT_W(9)) dut9 (
        .i_clock(clk), .i_reset_n(rst_n), .i_sample(b_sample), .i_load(b_load),
        .i_load_ch(b_ch), .i_levels(b_levels), .i_execute(b_exec),
        .o_busy(b_busy), .o_valid(b_valid), .o_output(b_out));

    mixer_n #(.NUM_CH(3)) dut3 (
        .i_clock(clk), .i_reset_n(rst_n), .i_sample(c_sample), .i_load(c_load),
        .i_load_ch(c_ch), .i_levels(c_levels), .i_execute(c_exec),
        .o_busy(c_busy), .o_valid(c_valid), .o_output(c_out));

    // Called just after a rising edge; returns just after a rising edge.
    task automatic load(input int sel, input logic [1:0] ch, input logic [7:0] val);
        case (sel)
            0: begin a_load = 1; a_ch = ch; a_sample = val; end
            1: begin b_load = 1; b_ch = ch; b_sample = val; end
            default: begin c_load = 1; c_ch = ch; c_sample = val; end
        endcase
        @(posedge clk); #1;
        a_load = 0; b_load = 0; c_load = 0;
    endtask

    // Pulses execute and observes 12 cycles after the execute edge (n=0 is just after E0).
    task automatic run_mix(input int sel, output logic [9:0] res, output int busy_n,
                           output int valid_n, output int lat);
        logic bz, vd;
        logic [9:0] ot;
        res = '0; busy_n = 0; valid_n = 0; lat = -1;
        case (sel)
            0: a_exec = 1;
            1: b_exec = 1;
            default: c_exec = 1;
        endcase
        @(posedge clk); #1;
        a_exec = 0; b_exec = 0; c_exec = 0;
        for (int n = 0; n < 12; n++) begin
            case (sel)
                0: begin bz = a_busy; vd = a_valid; ot = a_out; end
                1: begin bz = b_busy; vd = b_valid; ot = {1'b0, b_out}; end
                default: begin bz = c_busy; vd = c_valid; ot = c_out; end
            endcase
            if (bz) busy_n++;
            if (vd) begin
                if (valid_n == 0) begin lat = n; res = ot; end
                valid_n++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_out !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b out=%0d expected 0 0 0", a_busy, a_valid, a_out);
        end
        n_checks++;
        if (b_out !== 9'd0 || c_out !== 10'd0 || b_busy !== 1'b0 || c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_aux: b_out=%0d c_out=%0d expected 0 0", b_out, c_out);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [9:0] r; int bn, vn, lt;
        load(0, 0, 200); load(0, 1, 100); load(0, 2, 50); load(0, 3, 255);
        a_levels = '0;
        run_mix(0, r, bn, vn, lt);
        n_checks++;
        if (r !== 10'd605) begin n_fail++; $display("FAIL basic_out: got %0d expected 605", r); end
        n_checks++;
        if (bn !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", bn); end
        n_checks++;
        if (vn !== 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected 1", vn); end
        n_checks++;
        if (lt !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", lt); end
        n_checks++;
        if (a_out !== 10'd605) begin n_fail++; $display("FAIL basic_hold: got %0d expected 605", a_out); end
    endtask

    task automatic test_levels_mute;
        logic [9:0] r; int bn, vn, lt;
        a_levels = {3'd0, 3'd7, 3'd2, 3'd1};
        run_mix(0, r, bn, vn, lt);
        n_checks++;
        if (r !== 10'd380) begin n_fail++; $display("FAIL levels_out: got %0d expected 380", r); end
        a_levels = 12'o7777;
        run_mix(0, r, bn, vn, lt);
        n_checks++;
        if (r !== 10'd0 || vn !== 1) begin
            n_fail++; $display("FAIL all_mute: got %0d valid_count %0d expected 0 1", r, vn);
        end
        a_levels = {3'd3, 3'd0, 3'd0, 3'd7};
        run_mix(0, r, bn, vn, lt);
        n_checks++;  // 0 + 100 + 50 + 31
        if (r !== 10'd181) begin n_fail++; $display("FAIL levels_mix2: got %0d expected 181", r); end
    endtask

    task automatic test_snapshot;
        logic [9:0] r; int bn, vn, lt;
        a_levels = '0;
        load(0, 0, 10); load(0, 1, 0); load(0, 2, 0); load(0, 3, 0);
        a_exec = 1; a_load = 1; a_ch = 0; a_sample = 99;
        @(posedge clk); #1;
        a_exec = 0; a_load = 0;
        a_levels[2:0] = 3'd7;
        vn = 0; r = '0;
        for (int n = 0; n < 10; n++) begin
            a_exec = (n == 1);
            if (a_valid) begin if (vn == 0) r = a_out; vn++; end
            @(posedge clk); #1;
        end
        a_exec = 0;
        n_checks++;
        if (r !== 10'd10) begin n_fail++; $display("FAIL snapshot_out: got %0d expected 10", r); end
        n_checks++;
        if (vn !== 1) begin n_fail++; $display("FAIL exec_during_accum: valid_count %0d expected 1", vn); end
        a_levels = '0;
        run_mix(0, r, bn, vn, lt);
        n_checks++;
        if (r !== 10'd99) begin n_fail++; $display("FAIL snapshot_next: got %0d expected 99", r); end
    endtask

    task automatic test_reset_mid_mix;
        logic [9:0] r; int bn, vn, lt;
        int seen;
        a_exec = 1;
        @(posedge clk); #1; a_exec = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0; #1;
        n_checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_out !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mix: busy=%b valid=%b out=%0d expected 0 0 0", a_busy, a_valid, a_out);
        end
        @(posedge clk); #1; rst_n = 1;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            if (a_valid || a_busy) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL reset_abort_quiet: got %0d active cycles expected 0", seen); end
        run_mix(0, r, bn, vn, lt);
        n_checks++;
        if (r !== 10'd0 || vn !== 1) begin
            n_fail++; $display("FAIL reset_cleared_latches: got %0d valid_count %0d expected 0 1", r, vn);
        end
    endtask

    task automatic test_overflow;
        logic [9:0] r; int bn, vn, lt;
        logic [9:0] exp_v;
`ifdef MIXER_N_SATURATE_EN
        exp_v = 10'd511;
`else
        exp_v = 10'd508;
`endif
        b_levels = '0;
        for (int k = 0; k < 4; k++) load(1, 2'(k), 8'd255);
        run_mix(1, r, bn, vn, lt);
        n_checks++;
        if (r !== exp_v || vn !== 1) begin
            n_fail++; $display("FAIL overflow_out: got %0d valid_count %0d expected %0d 1", r, vn, exp_v);
        end
        b_levels = {3'd0, 3'd0, 3'd7, 3'd7};
        run_mix(1, r, bn, vn, lt);
        n_checks++;  // 510 fits in 9 bits either way
        if (r !== 10'd510) begin n_fail++; $display("FAIL overflow_fit: got %0d expected 510", r); end
    endtask

    task automatic test_invalid_load;
        logic [9:0] r; int bn, vn, lt;
        c_levels = '0;
        load(2, 0, 1); load(2, 1, 2); load(2, 2, 3);
        load(2, 3, 77);
        run_mix(2, r, bn, vn, lt);
        n_checks++;
        if (r !== 10'd6) begin n_fail++; $display("FAIL invalid_load_out: got %0d expected 6", r); end
        n_checks++;
        if (bn !== 3 || lt !== 3) begin
            n_fail++; $display("FAIL three_ch_timing: busy %0d latency %0d expected 3 3", bn, lt);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_levels_mute;
        test_snapshot;
        test_reset_mid_mix;
        test_overflow;
        test_invalid_load;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
